// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 width/sign codes
//   - FSM state enum (split states exist only when MISALIGN_SPLIT_EN is defined)
//   - base_mask(funct3): byte-enable pattern before shifting by the address offset
//   - is_legal(we, funct3): funct3 codes the unit accepts for loads/stores
// Configuration macro: MISALIGN_SPLIT_EN (word-crossing accesses become two memory accesses).
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_WAIT = 3'd1,
    S_LD_CAP  = 3'd2
`ifdef MISALIGN_SPLIT_EN
    ,
    S_LD_CAP2 = 3'd3,
    S_ST2     = 3'd4
`endif
  } lsu_state_e;

  function automatic logic [3:0] base_mask(input logic [2:0] funct3);
    logic [3:0] m;
    case (funct3)
      F3_B, F3_BU: m = 4'b0001;
      F3_H, F3_HU: m = 4'b0011;
      F3_W:        m = 4'b1111;
      default:     m = 4'b0000;
    endcase
    return m;
  endfunction

  // Stores have no unsigned variants, so BU/HU are only legal for loads.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: all bus signals of the load/store unit, request side and memory side.
//   Request side : i_req, i_we, i_funct3, i_addr, i_wdata -> o_ready, o_ld_valid,
//                  o_ld_data, o_err
//   Memory side  : o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_wren <- i_mem_rdata
// Handshake: a request transfers on a rising edge where i_req && o_ready. While o_ready
// is low the requester holds i_req and its fields stable; the unit ignores i_req then.
// o_ld_valid / o_err are single-cycle pulses with no back-pressure.
// Modports: master = environment (core + memory), slave = the load/store unit.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              i_req;
  logic              i_we;
  logic [2:0]        i_funct3;
  logic [31:0]       i_addr;
  logic [31:0]       i_wdata;
  logic              o_ready;
  logic              o_ld_valid;
  logic [31:0]       o_ld_data;
  logic              o_err;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [3:0]        o_mem_mask;
  logic              o_mem_wren;
  logic [31:0]       i_mem_rdata;

  modport master (
    output i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
    input  o_ready, o_ld_valid, o_ld_data, o_err,
           o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_wren
  );

  modport slave (
    input  i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
    output o_ready, o_ld_valid, o_ld_data, o_err,
           o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_wren
  );
endinterface

// File: rtl/lsu_load_fmt.sv
// lsu_load_fmt: combinational load-result formatter.
//   i_word0/i_word1 : word at A and at A+4 (i_word1 is zero for non-crossing loads)
//   i_off           : byte offset within the first word
//   i_funct3        : width/sign code
//   o_data          : ({word1,word0} >> 8*off)[31:0], sign- or zero-extended
module lsu_load_fmt
  import lsu_pkg::*;
(
  input  logic [31:0] i_word0,
  input  logic [31:0] i_word1,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);
  logic [63:0] win;
  logic        unused_win;

  assign win        = {i_word1, i_word0} >> {i_off, 3'b000};
  assign unused_win = ^win[63:32];

  always_comb begin
    o_data = win[31:0];
    case (i_funct3)
      F3_B:    o_data = {{24{win[7]}}, win[7:0]};
      F3_H:    o_data = {{16{win[15]}}, win[15:0]};
      F3_BU:   o_data = {24'h0, win[7:0]};
      F3_HU:   o_data = {16'h0, win[15:0]};
      default: o_data = win[31:0];
    endcase
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store unit in front of a byte-masked, one-cycle-latency memory.
//   i_clk, i_reset (async, active low)
//   bus (lsu_ctrl_if.slave): request handshake, load result/err pulses, memory port
//   o_dbg_state: current FSM state
// All memory-side outputs are registered. Store data/masks are lane-aligned from the
// byte offset; loads are captured and formatted by lsu_load_fmt.
// Configuration macro: MISALIGN_SPLIT_EN -- when defined, word-crossing accesses are
// issued as two word accesses (A then A+4); otherwise they are rejected with o_err.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic       i_clk,
  input  logic       i_reset,
  lsu_ctrl_if.slave  bus,
  output lsu_state_e o_dbg_state
);

  // Request decode
  logic [1:0]        off;
  logic [ADDR_W-1:0] a_word;
  logic [7:0]        lane8;
  logic [63:0]       st64;
  logic              crossing;
  logic              reject;

  assign off      = bus.i_addr[1:0];
  assign a_word   = {bus.i_addr[ADDR_W-1:2], 2'b00};
  assign lane8    = {4'b0000, base_mask(bus.i_funct3)} << off;
  assign st64     = {32'h0, bus.i_wdata} << {off, 3'b000};
  assign crossing = |lane8[7:4];
  assign reject   = !is_legal(bus.i_we, bus.i_funct3) || (crossing && !SPLIT_EN);

  // State
  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_mask_q, mem_mask_d;
  logic              mem_wren_q, mem_wren_d;
  logic              ld_valid_q, ld_valid_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic              err_q, err_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
`ifdef MISALIGN_SPLIT_EN
  logic              split_q, split_d;
  logic [ADDR_W-1:0] hi_addr_q, hi_addr_d;
  logic [3:0]        hi_mask_q, hi_mask_d;
  logic [31:0]       hi_wdata_q, hi_wdata_d;
  logic [31:0]       word0_q, word0_d;
`endif

  // Formatter: in S_LD_CAP2 the first word was captured a cycle earlier and the
  // memory is now returning the second one.
  logic [31:0] fmt_w0, fmt_w1, fmt_out;
`ifdef MISALIGN_SPLIT_EN
  assign fmt_w0 = (state_q == S_LD_CAP2) ? word0_q : bus.i_mem_rdata;
  assign fmt_w1 = (state_q == S_LD_CAP2) ? bus.i_mem_rdata : 32'h0;
`else
  assign fmt_w0 = bus.i_mem_rdata;
  assign fmt_w1 = 32'h0;
`endif

  lsu_load_fmt u_fmt (
    .i_word0  (fmt_w0),
    .i_word1  (fmt_w1),
    .i_off    (off_q),
    .i_funct3 (f3_q),
    .o_data   (fmt_out)
  );

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    mem_wren_d  = 1'b0;
    ld_valid_d  = 1'b0;
    ld_data_d   = ld_data_q;
    err_d       = 1'b0;
    off_d       = off_q;
    f3_d        = f3_q;
`ifdef MISALIGN_SPLIT_EN
    split_d     = split_q;
    hi_addr_d   = hi_addr_q;
    hi_mask_d   = hi_mask_q;
    hi_wdata_d  = hi_wdata_q;
    word0_d     = word0_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.i_req) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            mem_addr_d  = a_word;
            mem_mask_d  = lane8[3:0];
            mem_wdata_d = st64[31:0];
            off_d       = off;
            f3_d        = bus.i_funct3;
`ifdef MISALIGN_SPLIT_EN
            split_d     = crossing;
            hi_addr_d   = a_word + ADDR_W'(4);  // wraps at the top of memory
            hi_mask_d   = lane8[7:4];
            hi_wdata_d  = st64[63:32];
`endif
            if (bus.i_we) begin
              mem_wren_d = 1'b1;
`ifdef MISALIGN_SPLIT_EN
              if (crossing) state_d = S_ST2;
`endif
            end else begin
              state_d = S_LD_WAIT;
            end
          end
        end
      end
      S_LD_WAIT: begin
        state_d = S_LD_CAP;
`ifdef MISALIGN_SPLIT_EN
        if (split_q) begin
          mem_addr_d = hi_addr_q;
          mem_mask_d = hi_mask_q;
        end
`endif
      end
      S_LD_CAP: begin
`ifdef MISALIGN_SPLIT_EN
        if (split_q) begin
          word0_d = bus.i_mem_rdata;
          state_d = S_LD_CAP2;
        end else
`endif
        begin
          ld_data_d  = fmt_out;
          ld_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
`ifdef MISALIGN_SPLIT_EN
      S_LD_CAP2: begin
        ld_data_d  = fmt_out;
        ld_valid_d = 1'b1;
        state_d    = S_IDLE;
      end
      S_ST2: begin
        mem_addr_d  = hi_addr_q;
        mem_mask_d  = hi_mask_q;
        mem_wdata_d = hi_wdata_q;
        mem_wren_d  = 1'b1;
        state_d     = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      mem_wren_q  <= 1'b0;
      ld_valid_q  <= 1'b0;
      ld_data_q   <= '0;
      err_q       <= 1'b0;
      off_q       <= '0;
      f3_q        <= '0;
`ifdef MISALIGN_SPLIT_EN
      split_q     <= 1'b0;
      hi_addr_q   <= '0;
      hi_mask_q   <= '0;
      hi_wdata_q  <= '0;
      word0_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
      mem_wren_q  <= mem_wren_d;
      ld_valid_q  <= ld_valid_d;
      ld_data_q   <= ld_data_d;
      err_q       <= err_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
`ifdef MISALIGN_SPLIT_EN
      split_q     <= split_d;
      hi_addr_q   <= hi_addr_d;
      hi_mask_q   <= hi_mask_d;
      hi_wdata_q  <= hi_wdata_d;
      word0_q     <= word0_d;
`endif
    end
  end

  assign bus.o_ready     = (state_q == S_IDLE);
  assign bus.o_ld_valid  = ld_valid_q;
  assign bus.o_ld_data   = ld_data_q;
  assign bus.o_err       = err_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_mask  = mem_mask_q;
  assign bus.o_mem_wren  = mem_wren_q;
  assign o_dbg_state     = state_q;

  // Upper address bits are outside the memory; the second store word only
  // matters when splitting is built in.
  logic unused_bits;
`ifdef MISALIGN_SPLIT_EN
  assign unused_bits = ^bus.i_addr[31:ADDR_W];
`else
  assign unused_bits = ^{bus.i_addr[31:ADDR_W], st64[63:32]};
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl with a byte-masked memory model.
// Loads push their expected result into exp_q and are popped when o_ld_valid pulses;
// memory-side writes and error pulses are checked at the cycle they must appear.
// Configuration macro: MISALIGN_SPLIT_EN selects split or reject expectations.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int ADDR_W = 11;

  logic       clk;
  logic       rst_n;
  lsu_state_e dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  lsu_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  logic [31:0] mem_arr [0:511];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 512; i++) mem_arr[i] <= 32'h0;
    end else if (bus.o_mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (bus.o_mem_mask[b]) mem_arr[bus.o_mem_addr[10:2]][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
    end
    bus.i_mem_rdata <= mem_arr[bus.o_mem_addr[10:2]];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // ---------------- drivers ----------------
  // Present a request at edge+1 and hold until accepted; returns at E0+1.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    int n = 0;
    while (bus.o_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before_req", {31'b0, bus.o_ready}, 32'd1);
    bus.i_req = 1'b1; bus.i_we = we; bus.i_funct3 = f3; bus.i_addr = addr; bus.i_wdata = wd;
    @(posedge clk); #1;
    bus.i_req = 1'b0;
  endtask

  task automatic expect_load(input string tag, input int lat);
    int n = 0;
    logic [31:0] exp;
    while (bus.o_ld_valid !== 1'b1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    check(tag, bus.o_ld_data, exp);
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] exp, input int lat);
    exp_q.push_back(exp);
    issue(1'b0, f3, addr, 32'h0);
    expect_load(tag, lat);
  endtask

  // Checks the write presented to memory in the current cycle.
  task automatic check_write(input string tag, input logic [31:0] addr,
                             input logic [3:0] mask, input logic [31:0] wd);
    check({tag, "_wren"}, {31'b0, bus.o_mem_wren}, 32'd1);
    check({tag, "_addr"}, {21'b0, bus.o_mem_addr}, addr);
    check({tag, "_mask"}, {28'b0, bus.o_mem_mask}, {28'b0, mask});
    check({tag, "_wdata"}, bus.o_mem_wdata & lanes(mask), wd & lanes(mask));
  endtask

  task automatic err_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr);
    issue(we, f3, addr, 32'hA5A5_A5A5);
    check({tag, "_err"}, {31'b0, bus.o_err}, 32'd1);
    check({tag, "_nowren"}, {31'b0, bus.o_mem_wren}, 32'd0);
    check({tag, "_ready"}, {31'b0, bus.o_ready}, 32'd1);
    @(posedge clk); #1;
    check({tag, "_err_pulse"}, {30'b0, bus.o_err, bus.o_ld_valid}, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_funct3 = 3'b0; bus.i_addr = 32'h0; bus.i_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, bus.o_ready}, 32'd1);
    check("rst_ld_valid", {31'b0, bus.o_ld_valid}, 32'd0);
    check("rst_err", {31'b0, bus.o_err}, 32'd0);
    check("rst_ld_data", bus.o_ld_data, 32'h0);
    check("rst_wren", {31'b0, bus.o_mem_wren}, 32'd0);
    check("rst_mem_addr", {21'b0, bus.o_mem_addr}, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Aligned word store, then one-cycle strobe
    issue(1'b1, F3_W, 32'h0000_0010, 32'hDEAD_BEEF);
    check_write("sw_10", 32'h010, 4'b1111, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("sw_10_wren_drop", {31'b0, bus.o_mem_wren}, 32'd0);

    load("lw_10", F3_W, 32'h0000_0010, 32'hDEAD_BEEF, 2);
    load("lb_13", F3_B, 32'h0000_0013, 32'hFFFF_FFDE, 2);
    load("lbu_13", F3_BU, 32'h0000_0013, 32'h0000_00DE, 2);
    load("lh_12", F3_H, 32'h0000_0012, 32'hFFFF_DEAD, 2);
    load("lhu_12", F3_HU, 32'h0000_0012, 32'h0000_DEAD, 2);

    // Byte store into lane 1
    issue(1'b1, F3_B, 32'h0000_0011, 32'h1234_5678);
    check_write("sb_11", 32'h010, 4'b0010, 32'h0000_7800);
    load("lw_10_after_sb", F3_W, 32'h0000_0010, 32'hDEAD_78EF, 2);

    // Upper address bits beyond ADDR_W are ignored
    load("lb_alias", F3_BU, 32'hFFFF_F810, 32'h0000_00EF, 2);

`ifdef MISALIGN_SPLIT_EN
    issue(1'b1, F3_W, 32'h0000_0014, 32'h1122_3344);
    check_write("sw_14", 32'h014, 4'b1111, 32'h1122_3344);
    load("lw_12_split", F3_W, 32'h0000_0012, 32'h3344_DEAD, 3);

    // Crossing halfword at the top of memory wraps to word 0
    issue(1'b1, F3_H, 32'h0000_07FF, 32'h0000_CAFE);
    check_write("sh_7ff_lo", 32'h7FC, 4'b1000, 32'hFE00_0000);
    check("sh_7ff_busy", {31'b0, bus.o_ready}, 32'd0);
    @(posedge clk); #1;
    check_write("sh_7ff_hi", 32'h000, 4'b0001, 32'h0000_00CA);
    @(posedge clk); #1;
    check("sh_7ff_done", {30'b0, bus.o_mem_wren, bus.o_ready}, 32'd1);
    load("lbu_7ff", F3_BU, 32'h0000_07FF, 32'h0000_00FE, 2);
    load("lbu_000", F3_BU, 32'h0000_0000, 32'h0000_00CA, 2);
`else
    err_req("lw_12_nosplit", 1'b0, F3_W, 32'h0000_0012);
    err_req("sh_7ff_nosplit", 1'b1, F3_H, 32'h0000_07FF);
    load("lw_10_unchanged", F3_W, 32'h0000_0010, 32'hDEAD_78EF, 2);
`endif

    err_req("ld_f3_011", 1'b0, 3'b011, 32'h0000_0010);
    err_req("st_f3_100", 1'b1, 3'b100, 32'h0000_0010);
    load("lw_after_err", F3_W, 32'h0000_0010, 32'hDEAD_78EF, 2);

    // Asynchronous reset while waiting to capture load data
    issue(1'b0, F3_W, 32'h0000_0010, 32'h0);
    @(posedge clk); #1;
    check("rst_mid_state", 32'(dbg_state), 32'(S_LD_CAP));
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", {31'b0, bus.o_ready}, 32'd1);
    check("rst_mid_ld_data", bus.o_ld_data, 32'h0);
    check("rst_mid_state_idle", 32'(dbg_state), 32'(S_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("rst_mid_no_ld_valid", {31'b0, bus.o_ld_valid}, 32'd0);
      @(posedge clk); #1;
    end
    // Memory model is cleared by the same reset
    load("lw_after_rst", F3_W, 32'h0000_0010, 32'h0000_0000, 2);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
